// File: rtl/bcd_arith_sequencer.sv
// Digit-serial BCD add/subtract sequencer driving a digit-addressed register file.
// Define BCD_SEQ_NEG_EN to build the 10's-complement pass that stores negative results as magnitude.
module bcd_arith_sequencer #(
  parameter int DIGITS = 4,
  parameter int IDXW   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            op,
  input  logic [3:0]      rd_digit,
  output logic [1:0]      reg_sel,
  output logic [IDXW-1:0] dig_idx,
  output logic            wr_en,
  output logic [3:0]      wr_digit,
  output logic            busy,
  output logic            done,
  output logic            neg,
  output logic            ovf,
  output logic            err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_WR,
    S_NEG_RD,
    S_NEG_WR,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic            op_q, op_d;
  logic [3:0]      a_q, a_d;
  logic [3:0]      b_q, b_d;
  logic            c_q, c_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            neg_q, neg_d;
  logic            ovf_q, ovf_d;
  logic            err_q, err_d;

  logic       rd_bad;
  logic [3:0] rd_val;
  logic [4:0] add_s;
  logic [4:0] sub_s;
  logic [4:0] neg_s;
  logic [3:0] dig;
  logic       cout;
  logic       last;

  always_comb begin
    rd_bad = (rd_digit > 4'd9);
    rd_val = rd_bad ? 4'd0 : rd_digit;
    add_s  = {1'b0, a_q} + {1'b0, b_q} + {4'b0, c_q};
    // Biased by 10 so the borrow shows up as a result below 10.
    sub_s  = 5'd10 + {1'b0, a_q} - {1'b0, b_q} - {4'b0, c_q};
    neg_s  = {1'b0, 4'd9 - a_q} + {4'b0, c_q};
    last   = (idx_q == IDXW'(DIGITS - 1));
    dig    = 4'd0;
    cout   = 1'b0;
    if (state_q == S_NEG_WR) begin
      cout = (neg_s > 5'd9);
      dig  = cout ? 4'(neg_s - 5'd10) : neg_s[3:0];
    end else if (op_q) begin
      cout = (sub_s < 5'd10);
      dig  = cout ? sub_s[3:0] : 4'(sub_s - 5'd10);
    end else begin
      cout = (add_s > 5'd9);
      dig  = cout ? 4'(add_s - 5'd10) : add_s[3:0];
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    idx_d   = idx_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          neg_d   = 1'b0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          idx_d   = '0;
          c_d     = 1'b0;
          state_d = S_RD_A;
        end
      end
      S_RD_A: begin
        a_d     = rd_val;
        err_d   = err_q | rd_bad;
        state_d = S_RD_B;
      end
      S_RD_B: begin
        b_d     = rd_val;
        err_d   = err_q | rd_bad;
        state_d = S_WR;
      end
      S_WR: begin
        c_d = cout;
        if (!last) begin
          idx_d   = idx_q + IDXW'(1);
          state_d = S_RD_A;
        end else if (cout && !op_q) begin
          ovf_d   = 1'b1;
          state_d = S_DONE;
        end else if (cout && op_q) begin
          neg_d   = 1'b1;
`ifdef BCD_SEQ_NEG_EN
          idx_d   = '0;
          c_d     = 1'b1;
          state_d = S_NEG_RD;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DONE;
        end
      end
`ifdef BCD_SEQ_NEG_EN
      S_NEG_RD: begin
        a_d     = rd_val;
        err_d   = err_q | rd_bad;
        state_d = S_NEG_WR;
      end
      S_NEG_WR: begin
        c_d = cout;
        if (!last) begin
          idx_d   = idx_q + IDXW'(1);
          state_d = S_NEG_RD;
        end else begin
          state_d = S_DONE;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      c_q     <= 1'b0;
      idx_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    reg_sel  = 2'd0;
    wr_en    = 1'b0;
    wr_digit = 4'd0;
    unique case (state_q)
      S_RD_A:   reg_sel = 2'd1;
      S_RD_B:   reg_sel = 2'd2;
      S_NEG_RD: reg_sel = 2'd3;
      S_WR, S_NEG_WR: begin
        reg_sel  = 2'd3;
        wr_en    = 1'b1;
        wr_digit = dig;
      end
      default: reg_sel = 2'd0;
    endcase
  end

  assign dig_idx = idx_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign neg     = neg_q;
  assign ovf     = ovf_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd_arith_sequencer.sv
// Directed bench for bcd_arith_sequencer with a register-file model and result scoreboard.
// Expectations follow BCD_SEQ_NEG_EN when it is defined for the build.
module tb_bcd_arith_sequencer;

  localparam int DIGITS = 4;
  localparam int IDXW   = 2;
  localparam int POW    = 10000;

`ifdef BCD_SEQ_NEG_EN
  localparam bit NEG_EN = 1'b1;
`else
  localparam bit NEG_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            op;
  logic [3:0]      rd_digit;
  logic [1:0]      reg_sel;
  logic [IDXW-1:0] dig_idx;
  logic            wr_en;
  logic [3:0]      wr_digit;
  logic            busy;
  logic            done;
  logic            neg;
  logic            ovf;
  logic            err;

  logic [15:0] r1;
  logic [15:0] r2;
  logic [15:0] r3 = 16'h0;
  int          wr_total = 0;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] r3;
    logic        neg;
    logic        ovf;
    logic        err;
    int          cyc;
    int          wr;
  } exp_t;

  exp_t sb[$];

  bcd_arith_sequencer #(.DIGITS(DIGITS), .IDXW(IDXW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .rd_digit (rd_digit),
    .reg_sel  (reg_sel),
    .dig_idx  (dig_idx),
    .wr_en    (wr_en),
    .wr_digit (wr_digit),
    .busy     (busy),
    .done     (done),
    .neg      (neg),
    .ovf      (ovf),
    .err      (err)
  );

  always #5 clk = ~clk;

  always_comb begin
    rd_digit = 4'd0;
    case (reg_sel)
      2'd1:    rd_digit = r1[{dig_idx, 2'b00} +: 4];
      2'd2:    rd_digit = r2[{dig_idx, 2'b00} +: 4];
      2'd3:    rd_digit = r3[{dig_idx, 2'b00} +: 4];
      default: rd_digit = 4'd0;
    endcase
  end

  always @(posedge clk) begin
    if (wr_en && reg_sel == 2'd3) r3[{dig_idx, 2'b00} +: 4] <= wr_digit;
    if (wr_en) wr_total <= wr_total + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    int acc = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      int d = int'(v[i*4 +: 4]);
      acc = acc * 10 + ((d > 9) ? 0 : d);
    end
    return acc;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r = '0;
    int x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic exp_t model(input logic o, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int   v;
    e.err = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (a[i*4 +: 4] > 4'd9 || b[i*4 +: 4] > 4'd9) e.err = 1'b1;
    e.neg = 1'b0;
    e.ovf = 1'b0;
    if (!o) begin
      v = bcd2int(a) + bcd2int(b);
      e.ovf = (v >= POW);
      v = v % POW;
    end else begin
      v = bcd2int(a) - bcd2int(b);
      e.neg = (v < 0);
      if (v < 0) v = NEG_EN ? -v : v + POW;
    end
    e.r3  = int2bcd(v);
    e.cyc = (e.neg && NEG_EN) ? 5 * DIGITS + 1 : 3 * DIGITS + 1;
    e.wr  = (e.neg && NEG_EN) ? 2 * DIGITS : DIGITS;
    return e;
  endfunction

  // Drives one operation and checks it when DONE appears; extra_at >0 re-pulses start while busy.
  task automatic run_op(input string tag, input logic o, input logic [15:0] a,
                        input logic [15:0] b, input int extra_at);
    exp_t e;
    int   cyc = 0;
    int   wr0;
    bit   seen = 1'b0;
    int   extra_done = 0;
    r1 = a;
    r2 = b;
    sb.push_back(model(o, a, b));
    @(negedge clk);
    wr0   = wr_total;
    op    = o;
    start = 1'b1;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = (extra_at > 0 && cyc == extra_at) ? 1'b1 : 1'b0;
      op    = ~o;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    e = sb.pop_front();
    chk({tag, ":done_seen"}, 32'(seen), 32'd1);
    chk({tag, ":done_cycle"}, 32'(cyc), 32'(e.cyc));
    chk({tag, ":busy_in_done"}, 32'(busy), 32'd1);
    chk({tag, ":flags"}, {29'd0, neg, ovf, err}, {29'd0, e.neg, e.ovf, e.err});
    chk({tag, ":r3"}, 32'(r3), 32'(e.r3));
    chk({tag, ":writes"}, 32'(wr_total - wr0), 32'(e.wr));
    @(negedge clk);
    chk({tag, ":done_pulse"}, {30'd0, done, busy}, 32'd0);
    chk({tag, ":flags_held"}, {29'd0, neg, ovf, err}, {29'd0, e.neg, e.ovf, e.err});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    chk({tag, ":extra_done"}, 32'(extra_done), 32'd0);
  endtask

  initial begin
    int cyc;
    int wr0;
    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    r1    = 16'h0;
    r2    = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst:outputs", {22'd0, reg_sel, dig_idx, wr_en, wr_digit},
        32'd0);
    chk("rst:status", {27'd0, busy, done, neg, ovf, err}, 32'd0);
    reset = 1'b0;

    run_op("add_0123_0456", 1'b0, 16'h0123, 16'h0456, 0);
    run_op("add_9999_0001", 1'b0, 16'h9999, 16'h0001, 0);
    run_op("sub_0500_0123", 1'b1, 16'h0500, 16'h0123, 0);
    run_op("sub_0123_0500", 1'b1, 16'h0123, 16'h0500, 0);
    run_op("add_001C_0001", 1'b0, 16'h001C, 16'h0001, 4);
    run_op("sub_0456_0456", 1'b1, 16'h0456, 16'h0456, 0);
    run_op("add_5678_4321", 1'b0, 16'h5678, 16'h4321, 0);
    run_op("sub_0000_9999", 1'b1, 16'h0000, 16'h9999, 0);

    r1 = 16'h001C;
    r2 = 16'h0001;
    @(negedge clk);
    op    = 1'b0;
    start = 1'b1;
    cyc   = 0;
    while (cyc < 5) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
    end
    chk("rstmid:err_before", {30'd0, busy, err}, 32'd3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wr0 = wr_total;
    chk("rstmid:status", {27'd0, busy, done, neg, ovf, err}, 32'd0);
    repeat (6) @(negedge clk);
    chk("rstmid:no_writes", 32'(wr_total - wr0), 32'd0);
    chk("rstmid:idle", {30'd0, busy, wr_en}, 32'd0);
    run_op("after_reset", 1'b0, 16'h0123, 16'h0456, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
